// File: rtl/dffram_2p_if.sv
// dffram_2p_if: write/read request ports and status of the two-port flip-flop RAM.
interface dffram_2p_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 10
) ();
    localparam int unsigned NB = DW / 8;

    logic          w_req;
    logic [AW-1:0] w_addr;
    logic [NB-1:0] w_be;
    logic [DW-1:0] w_data;
    logic          w_gnt;

    logic          r_req;
    logic [AW-1:0] r_addr;
    logic          r_gnt;
    logic          r_valid;
    logic [DW-1:0] r_data;

    logic          busy;

    modport master (
        output w_req, w_addr, w_be, w_data, r_req, r_addr,
        input  w_gnt, r_gnt, r_valid, r_data, busy
    );

    modport slave (
        input  w_req, w_addr, w_be, w_data, r_req, r_addr,
        output w_gnt, r_gnt, r_valid, r_data, busy
    );
endinterface

// File: rtl/dffram_2p.sv
// dffram_2p: parametrised 1R1W flip-flop RAM with byte-lane writes, req/gnt
// handshake and an optional post-reset zero-fill sweep.
// Build option: DFFRAM_2P_WR_FWD_EN selects write-first data on a same-address
// read/write collision; left undefined, the read returns the old word.
module dffram_2p #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 10,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic        CLK,
    input  logic        RST,
    dffram_2p_if.slave  bus
);
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FILL  = 2'd1,
        S_IDLE  = 2'd2
    } state_t;

    localparam state_t S_POST_RST = (INIT_ZERO != 0) ? S_FILL : S_IDLE;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_busy;
    logic          w_busy_nxt;

    logic [DW-1:0] r_mem [DEPTH];
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_fill_en;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_rd_word;

    assign w_wr_en     = bus.w_req & ~r_busy;
    assign w_rd_en     = bus.r_req & ~r_busy;
    assign bus.w_gnt   = w_wr_en;
    assign bus.r_gnt   = w_rd_en;
    assign bus.busy    = r_busy;
    assign bus.r_valid = r_rvalid;
    assign bus.r_data  = r_rdata;

    // State, fill counter and busy flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_POST_RST;
            r_cnt   <= '0;
            r_busy  <= (INIT_ZERO != 0);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state logic: sweep every word once in FILL, then park in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RESET: begin
                w_state_nxt = S_POST_RST;
                w_cnt_nxt   = '0;
            end
            S_FILL: begin
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_POST_RST;
                w_cnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_FILL);
        w_fill_en  = (r_state == S_FILL) & ~RST;
    end

    // Byte-lane merge of the addressed word with the enabled write-data lanes.
    always_comb begin
        w_merged = r_mem[bus.w_addr];
        for (int i = 0; i < NB; i++) begin
            if (bus.w_be[i]) begin
                w_merged[8*i +: 8] = bus.w_data[8*i +: 8];
            end
        end
    end

    // Read data source, including the same-address collision policy.
    always_comb begin
`ifdef DFFRAM_2P_WR_FWD_EN
        w_rd_word = (w_wr_en && (bus.w_addr == bus.r_addr)) ? w_merged : r_mem[bus.r_addr];
`else
        w_rd_word = r_mem[bus.r_addr];
`endif
    end

    // Storage array: zero sweep during FILL, masked writes otherwise; untouched in reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (w_fill_en) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_en) begin
                r_mem[bus.w_addr] <= w_merged;
            end
        end
    end

    // Registered read port: one-cycle valid pulse, data held between reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd_en;
            if (w_rd_en) begin
                r_rdata <= w_rd_word;
            end
        end
    end
endmodule

// File: tb/tb_dffram_2p.sv
// tb_dffram_2p: directed checks of dffram_2p in a 32x16 zero-fill build and a
// 64x64 no-fill build.
module tb_dffram_2p;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    dffram_2p_if #(.DW(32), .AW(4)) bus0 ();
    dffram_2p_if #(.DW(64), .AW(6)) bus1 ();

    dffram_2p #(.DW(32), .AW(4), .INIT_ZERO(1)) u_dut0 (
        .CLK (clk),
        .RST (rst0),
        .bus (bus0)
    );

    dffram_2p #(.DW(64), .AW(6), .INIT_ZERO(0)) u_dut1 (
        .CLK (clk),
        .RST (rst1),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr0(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        bus0.w_req  = 1'b1;
        bus0.w_addr = a;
        bus0.w_be   = be;
        bus0.w_data = d;
        #1 check_eq("wr0_gnt", 64'(bus0.w_gnt), 64'd1);
        tick();
        bus0.w_req = 1'b0;
    endtask

    task automatic rd0(input logic [3:0] a, input logic [31:0] exp, input string tag);
        bus0.r_req  = 1'b1;
        bus0.r_addr = a;
        tick();
        bus0.r_req = 1'b0;
        check_eq({tag, "_valid"}, 64'(bus0.r_valid), 64'd1);
        check_eq(tag, 64'(bus0.r_data), 64'(exp));
    endtask

    task automatic wr1(input logic [5:0] a, input logic [7:0] be, input logic [63:0] d);
        bus1.w_req  = 1'b1;
        bus1.w_addr = a;
        bus1.w_be   = be;
        bus1.w_data = d;
        #1 check_eq("wr1_gnt", 64'(bus1.w_gnt), 64'd1);
        tick();
        bus1.w_req = 1'b0;
    endtask

    task automatic rd1(input logic [5:0] a, input logic [63:0] exp, input string tag);
        bus1.r_req  = 1'b1;
        bus1.r_addr = a;
        tick();
        bus1.r_req = 1'b0;
        check_eq({tag, "_valid"}, 64'(bus1.r_valid), 64'd1);
        check_eq(tag, bus1.r_data, exp);
    endtask

    // Count cycles with busy high (bounded) and confirm no grant leaks out.
    task automatic wait_fill0(input string tag);
        int n;
        logic gnt_seen;
        n        = 0;
        gnt_seen = 1'b0;
        while (bus0.busy === 1'b1 && n < 100) begin
            #1;
            if (bus0.r_gnt !== 1'b0 || bus0.w_gnt !== 1'b0) gnt_seen = 1'b1;
            tick();
            n++;
        end
        check_eq({tag, "_len"}, 64'(n), 64'd16);
        check_eq({tag, "_nogrant"}, 64'(gnt_seen), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_coll;
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.w_req = 1'b0; bus0.w_addr = '0; bus0.w_be = '0; bus0.w_data = '0;
        bus0.r_req = 1'b0; bus0.r_addr = '0;
        bus1.w_req = 1'b0; bus1.w_addr = '0; bus1.w_be = '0; bus1.w_data = '0;
        bus1.r_req = 1'b0; bus1.r_addr = '0;

        @(negedge clk);
        tick();
        // Requests held through the last reset edge and the whole fill.
        bus0.r_req  = 1'b1;
        bus0.r_addr = 4'd0;
        bus0.w_req  = 1'b1;
        bus0.w_addr = 4'd2;
        bus0.w_be   = 4'hF;
        bus0.w_data = 32'hFFFF_FFFF;
        tick();
        check_eq("rst_busy0", 64'(bus0.busy), 64'd1);
        check_eq("rst_rvalid0", 64'(bus0.r_valid), 64'd0);
        check_eq("rst_rdata0", 64'(bus0.r_data), 64'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        check_eq("nofill_busy1", 64'(bus1.busy), 64'd0);

        wait_fill0("fill");
        bus0.w_req = 1'b0;
        #1 check_eq("first_rgnt", 64'(bus0.r_gnt), 64'd1);
        bus0.r_req = 1'b0;
        for (int a = 0; a < 16; a++) rd0(4'(a), 32'h0, "fill_rd");

        // Byte mask and zero mask.
        wr0(4'd3, 4'hF, 32'hAABB_CCDD);
        wr0(4'd3, 4'b0101, 32'h1122_3344);
        rd0(4'd3, 32'hAA22_CC44, "mask");
        wr0(4'd3, 4'h0, 32'hFFFF_FFFF);
        rd0(4'd3, 32'hAA22_CC44, "be_zero");

        // Back-to-back reads.
        wr0(4'd1, 4'hF, 32'h1111_1111);
        wr0(4'd2, 4'hF, 32'h2222_2222);
        bus0.r_req  = 1'b1;
        bus0.r_addr = 4'd1;
        tick();
        check_eq("b2b1_valid", 64'(bus0.r_valid), 64'd1);
        check_eq("b2b1_data", 64'(bus0.r_data), 64'h1111_1111);
        bus0.r_addr = 4'd2;
        tick();
        check_eq("b2b2_valid", 64'(bus0.r_valid), 64'd1);
        check_eq("b2b2_data", 64'(bus0.r_data), 64'h2222_2222);
        bus0.r_addr = 4'd3;
        tick();
        check_eq("b2b3_valid", 64'(bus0.r_valid), 64'd1);
        check_eq("b2b3_data", 64'(bus0.r_data), 64'hAA22_CC44);
        bus0.r_req = 1'b0;
        tick();
        check_eq("b2b_end_valid", 64'(bus0.r_valid), 64'd0);
        check_eq("b2b_end_hold", 64'(bus0.r_data), 64'hAA22_CC44);

        // Same-address collision.
`ifdef DFFRAM_2P_WR_FWD_EN
        exp_coll = 32'h0000_BEEF;
`else
        exp_coll = 32'h0000_0000;
`endif
        wr0(4'd5, 4'hF, 32'h0);
        bus0.w_req  = 1'b1;
        bus0.w_addr = 4'd5;
        bus0.w_be   = 4'b0011;
        bus0.w_data = 32'hDEAD_BEEF;
        bus0.r_req  = 1'b1;
        bus0.r_addr = 4'd5;
        tick();
        bus0.w_req = 1'b0;
        bus0.r_req = 1'b0;
        check_eq("coll_valid", 64'(bus0.r_valid), 64'd1);
        check_eq("coll_data", 64'(bus0.r_data), 64'(exp_coll));
        rd0(4'd5, 32'h0000_BEEF, "coll_after");

        // Reset mid-fill: dirty every word, start a fill, abort at cnt=7.
        for (int a = 0; a < 16; a++) wr0(4'(a), 4'hF, 32'hC0DE_0000 | 32'(a));
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        repeat (7) tick();
        rst0 = 1'b1;
        tick();
        check_eq("midfill_busy", 64'(bus0.busy), 64'd1);
        rst0 = 1'b0;
        wait_fill0("refill");
        for (int a = 0; a < 16; a++) rd0(4'(a), 32'h0, "refill_rd");

        // Wide build: single top-lane write.
        wr1(6'd10, 8'hFF, 64'h0123_4567_89AB_CDEF);
        wr1(6'd10, 8'h80, 64'hFEDC_BA98_7654_3210);
        rd1(6'd10, 64'hFE23_4567_89AB_CDEF, "lane7");

        // Reset with a read in flight drops the valid and clears data.
        bus1.r_req  = 1'b1;
        bus1.r_addr = 6'd10;
        rst1 = 1'b1;
        tick();
        bus1.r_req = 1'b0;
        rst1 = 1'b0;
        check_eq("rst_rd_valid", 64'(bus1.r_valid), 64'd0);
        check_eq("rst_rd_data", bus1.r_data, 64'd0);
        check_eq("nofill_busy1_b", 64'(bus1.busy), 64'd0);
        rd1(6'd10, 64'hFE23_4567_89AB_CDEF, "lane7_keep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
